// File: rtl/fetch_unit.sv
// Program counter and fetch stage in front of the instruction memory.
// Holds the fetched word in an IR, offers it to decode with valid/ready, redirects on branches and halts at end of program.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [15:0]       inst_in,
  input  logic              id_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [15:0]       ir,
  output logic [5:0]        opcode,
  output logic [4:0]        field_a,
  output logic [4:0]        field_b,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_FETCH = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [15:0]       ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              halted_q, halted_d;
  logic              inst_unknown;
  logic              stall;

  // Memory returns all-Z past the last instruction; only visible in simulation.
  assign inst_unknown = $isunknown(inst_in);
  assign stall        = ir_valid_q && !id_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_out_d   = pc_out_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    halted_d   = halted_q;
    case (state_q)
      S_IDLE: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = S_FILL;
        end else if (start) begin
          pc_d    = RESET_PC;
          state_d = S_FILL;
        end
      end
      // inst_in already reflects pc by the end of the bubble, so FILL's closing edge loads the IR.
      S_FILL, S_FETCH: begin
        if (branch_taken) begin
          pc_d       = branch_target;
          ir_valid_d = 1'b0;
          state_d    = S_FILL;
        end else if (inst_unknown) begin
          if (!stall) begin
            ir_valid_d = 1'b0;
            halted_d   = 1'b1;
            state_d    = S_HALT;
          end
        end else if (!stall) begin
          ir_d       = inst_in;
          pc_out_d   = pc_q;
          ir_valid_d = 1'b1;
          pc_d       = pc_q + ADDR_W'(1);
          state_d    = S_FETCH;
        end
      end
      S_HALT: begin
        ir_valid_d = 1'b0;
        if (start) begin
          pc_d     = RESET_PC;
          halted_d = 1'b0;
          state_d  = S_FILL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      pc_out_q   <= '0;
      ir_q       <= 16'h0000;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_out_q   <= pc_out_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign inst_addr = pc_q;
  assign ir        = ir_q;
  assign opcode    = ir_q[15:10];
  assign field_a   = ir_q[9:5];
  assign field_b   = ir_q[4:0];
  assign ir_valid  = ir_valid_q;
  assign pc_out    = pc_out_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed program walk-through plus randomized traffic against a behavioural model.
module tb_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [1:0]  M_IDLE = 2'd0, M_FILL = 2'd1, M_RUN = 2'd2, M_HALT = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        id_ready = 1'b1;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] prog_len = 16'd7;

  wire  [15:0] inst_addr, ir, pc_out;
  wire  [5:0]  opcode;
  wire  [4:0]  field_a, field_b;
  wire         ir_valid, halted;

  logic [15:0] mem_q = 16'h0000;
  logic        mem_drv = 1'b0;
  wire  [15:0] inst_w;
  logic        probe_en = 1'b0;
  wire  [15:0] zprobe;
  logic        z_det = 1'b0;

  int checks = 0;
  int errors = 0;

  assign inst_w = mem_drv ? mem_q : 16'hzzzz;
  assign zprobe = probe_en ? 16'h0000 : 16'hzzzz;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(16), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .inst_addr(inst_addr), .inst_in(inst_w),
    .id_ready(id_ready), .branch_taken(branch_taken), .branch_target(branch_target),
    .ir(ir), .opcode(opcode), .field_a(field_a), .field_b(field_b),
    .ir_valid(ir_valid), .pc_out(pc_out), .halted(halted)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'd0:   return 16'h2801;
      16'd1:   return 16'h0422;
      16'd2:   return 16'h0443;
      16'd3:   return 16'h3005;
      16'd4:   return 16'h4005;
      16'd5:   return 16'h4006;
      16'd6:   return 16'h0C46;
      default: return (a * 16'h9E37) ^ 16'h5A5A;
    endcase
  endfunction

  function automatic logic in_prog(input logic [15:0] a);
    return (a < prog_len) || (a >= 16'hFFF0);
  endfunction

  // Memory presents the word for the current address on every falling edge.
  always @(negedge clk) begin
    mem_q   <= mem_word(inst_addr);
    mem_drv <= in_prog(inst_addr);
  end

  typedef struct packed {
    logic [1:0]  mode;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] pc_out;
    logic        valid;
    logic        halted;
  } model_t;

  model_t m;

  function automatic model_t model_next(input model_t s, input logic st, input logic rdy,
                                        input logic br, input logic [15:0] tgt,
                                        input logic [15:0] word, input logic eop);
    model_t n = s;
    logic   free = !s.valid || rdy;
    if (s.mode == M_IDLE) begin
      if (br)      begin n.pc = tgt;      n.mode = M_FILL; end
      else if (st) begin n.pc = RESET_PC; n.mode = M_FILL; end
    end else if (s.mode == M_HALT) begin
      n.valid = 1'b0;
      if (st) begin n.pc = RESET_PC; n.halted = 1'b0; n.mode = M_FILL; end
    end else if (br) begin
      n.pc = tgt; n.valid = 1'b0; n.mode = M_FILL;
    end else if (eop) begin
      if (free) begin n.valid = 1'b0; n.halted = 1'b1; n.mode = M_HALT; end
    end else if (free) begin
      n.ir = word; n.pc_out = s.pc; n.valid = 1'b1; n.pc = s.pc + 16'd1; n.mode = M_RUN;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '{mode: M_IDLE, pc: RESET_PC, ir: 16'h0000, pc_out: 16'h0000, valid: 1'b0, halted: 1'b0};
    end else begin
      m <= model_next(m, start, id_ready, branch_taken, branch_target,
                      in_prog(m.pc) ? mem_word(m.pc) : inst_w,
                      !in_prog(m.pc) && $isunknown(inst_w));
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("inst_addr", inst_addr, m.pc);
    chk("ir_valid", 16'(ir_valid), 16'(m.valid));
    chk("halted", 16'(halted), 16'(m.halted));
    chk("ir", ir, m.ir);
    chk("pc_out", pc_out, m.pc_out);
    chk("opcode", 16'(opcode), 16'(m.ir[15:10]));
    chk("field_a", 16'(field_a), 16'(m.ir[9:5]));
    chk("field_b", 16'(field_b), 16'(m.ir[4:0]));
    if (m.valid && in_prog(m.pc_out))
      chk("ir_is_mem_at_pc_out", ir, mem_word(m.pc_out));
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0; start = 1'b0; branch_taken = 1'b0; id_ready = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #1 z_det = $isunknown(zprobe);
    tick();
    chk("reset_ir_valid", 16'(ir_valid), 16'd0);
    chk("reset_inst_addr", inst_addr, RESET_PC);
    tick();
    rst_n = 1'b1;
    tick();

    // Program walk: bubble, then 0,1,2,3; branch to 5 skips 4.
    pulse_start();
    chk("fill_bubble_valid", 16'(ir_valid), 16'd0);
    tick();
    chk("first_ir", ir, 16'b001010_00000_00001);
    chk("first_pc_out", pc_out, 16'd0);
    tick();
    chk("second_pc_out", pc_out, 16'd1);
    tick();
    chk("third_pc_out", pc_out, 16'd2);
    tick();
    chk("brz_pc_out", pc_out, 16'd3);
    branch_taken = 1'b1; branch_target = 16'd5;
    tick();
    branch_taken = 1'b0;
    chk("flush_valid", 16'(ir_valid), 16'd0);
    chk("flush_inst_addr", inst_addr, 16'd5);
    tick();
    chk("target_valid", 16'(ir_valid), 16'd1);
    chk("target_ir", ir, 16'b010000_00000_00110);
    chk("target_pc_out", pc_out, 16'd5);
    tick();
    chk("st_pc_out", pc_out, 16'd6);
    tick();
    if (z_det) begin
      chk("eop_halted", 16'(halted), 16'd1);
      chk("eop_valid", 16'(ir_valid), 16'd0);
      chk("eop_inst_addr", inst_addr, 16'd7);
      tick();
      chk("eop_hold_addr", inst_addr, 16'd7);
      pulse_start();
      chk("restart_halted", 16'(halted), 16'd0);
      tick();
      chk("restart_pc_out", pc_out, 16'd0);
    end

    // Stall for 3 cycles while address 1 is in the IR.
    do_reset();
    pulse_start();
    tick();
    tick();
    chk("pre_stall_pc_out", pc_out, 16'd1);
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ir", ir, 16'h0422);
      chk("stall_pc_out", pc_out, 16'd1);
      chk("stall_inst_addr", inst_addr, 16'd2);
      chk("stall_valid", 16'(ir_valid), 16'd1);
    end
    id_ready = 1'b1;
    tick();
    chk("release_pc_out", pc_out, 16'd2);
    tick();
    chk("release_next_pc_out", pc_out, 16'd3);

    // Asynchronous reset between edges while fetching.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 16'(ir_valid), 16'd0);
    chk("async_rst_addr", inst_addr, RESET_PC);
    chk("async_rst_halted", 16'(halted), 16'd0);
    chk("async_rst_pc_out", pc_out, 16'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_hold_addr", inst_addr, RESET_PC);

    // Branch from idle to the top of memory; pc wraps to 0.
    branch_taken = 1'b1; branch_target = 16'hFFFF;
    tick();
    branch_taken = 1'b0;
    chk("wrap_fill_addr", inst_addr, 16'hFFFF);
    tick();
    chk("wrap_pc_out", pc_out, 16'hFFFF);
    chk("wrap_ir", ir, 16'h3B93);
    chk("wrap_inst_addr", inst_addr, 16'h0000);
    tick();
    chk("wrap_next_pc_out", pc_out, 16'h0000);

    // Randomized traffic with occasional mid-cycle resets.
    tick();
    rst_n = 1'b0;
    prog_len = 16'h0100;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      start        = ($urandom_range(0, 15) == 0);
      id_ready     = ($urandom_range(0, 3) != 0);
      branch_taken = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 7) == 0)
        branch_target = 16'hFFF8 + 16'($urandom_range(0, 7));
      else
        branch_target = 16'($urandom_range(0, 16'h011F));
      if (!rst_n)
        rst_n = 1'b1;
      else if ($urandom_range(0, 299) == 0)
        rst_n = 1'b0;
    end
    rst_n = 1'b1; start = 1'b0; branch_taken = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
